// File: rtl/bitrev_spi_ctrl.sv
// bitrev_spi_ctrl
//   SPI master that runs one transaction with the bitrev SPI slave per
//   accepted request: one SCK pulse with ss high (puts the slave into its
//   receive state), 8 pulses sending the request byte MSB-first on MOSI,
//   then 8 pulses clocking the answer back on MISO.
//
// Parameters
//   DIV        clock cycles per SCK half-period (1..255)
//
// Ports
//   clock      single clock, rising edge
//   resetn     synchronous active-low reset
//   req_valid  / req_ready / req_data   CPU-side request (accepted in IDLE)
//   resp_valid / resp_ready / resp_data received byte, MSB = first bit in
//   busy       high whenever the controller is not idle
//   err        loop-check mismatch flag (0 unless BITREV_CTRL_LOOPCHK_EN)
//   spi_sck    SPI clock, idles low (flop output)
//   spi_ss     slave select, active-low (flop output)
//   spi_mosi   master data out (flop output)
//   spi_miso   slave data in
//
// Configuration macro
//   BITREV_CTRL_LOOPCHK_EN  when defined, err flags a response that is not
//                           the bit-reverse of the transmitted byte.
module bitrev_spi_ctrl #(
    parameter int DIV = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       busy,
    output logic       err,
    output logic       spi_sck,
    output logic       spi_ss,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [7:0] HALF_LAST = 8'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TX,
        S_RX,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] half_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;

    logic       active;
    logic       half_end;
    logic       pulse_end;
    logic       last_bit;
    logic       accept;

    // A pulse ends on the last cycle of its high phase; the next low phase
    // (or the exit from the pulse-generating states) starts on that edge.
    always_comb begin
        active    = (state == S_PRE) || (state == S_TX) || (state == S_RX);
        half_end  = active && (half_cnt == HALF_LAST);
        pulse_end = half_end && spi_sck;
        last_bit  = (bit_cnt == 3'd7);
        accept    = (state == S_IDLE) && req_valid;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                if (pulse_end) begin
                    state_nxt = S_TX;
                end
            end
            S_TX: begin
                if (pulse_end && last_bit) begin
                    state_nxt = S_RX;
                end
            end
            S_RX: begin
                if (pulse_end && last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // SCK generation, shift registers and pin flops. tx_sr is pure data and
    // is only loaded on accept, so it is left out of the reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            half_cnt <= 8'd0;
            bit_cnt  <= 3'd0;
            spi_sck  <= 1'b0;
            spi_ss   <= 1'b1;
            spi_mosi <= 1'b0;
            rx_sr    <= 8'd0;
        end else begin
            if (accept) begin
                tx_sr    <= req_data;
                half_cnt <= 8'd0;
                bit_cnt  <= 3'd0;
                spi_sck  <= 1'b0;
            end
            if (active) begin
                if (half_end) begin
                    half_cnt <= 8'd0;
                    spi_sck  <= ~spi_sck;
                end else begin
                    half_cnt <= half_cnt + 8'd1;
                end
            end
            if (pulse_end) begin
                case (state)
                    S_PRE: begin
                        // First TX low phase begins here: present bit 7.
                        spi_ss   <= 1'b0;
                        spi_mosi <= tx_sr[7];
                        tx_sr    <= {tx_sr[6:0], 1'b0};
                        bit_cnt  <= 3'd0;
                    end
                    S_TX: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            spi_mosi <= 1'b0;
                        end else begin
                            spi_mosi <= tx_sr[7];
                            tx_sr    <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    S_RX: begin
                        // MISO changed on the SCK rise DIV cycles ago, so it
                        // is settled by the end of the high phase.
                        rx_sr   <= {rx_sr[6:0], spi_miso};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            spi_ss <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign resp_data = rx_sr;

`ifdef BITREV_CTRL_LOOPCHK_EN
    logic [7:0] tx_copy;

    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7 - i];
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (accept) begin
            tx_copy <= req_data;
        end
    end

    assign err = (state == S_DONE) && (rx_sr != bit_rev(tx_copy));
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bitrev_spi_ctrl.sv
module tb_bitrev_spi_ctrl;

    localparam int NU = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn     [NU];
    logic       req_valid  [NU];
    logic       req_ready  [NU];
    logic [7:0] req_data   [NU];
    logic       resp_valid [NU];
    logic       resp_ready [NU];
    logic [7:0] resp_data  [NU];
    logic       busy       [NU];
    logic       err        [NU];
    logic       sck        [NU];
    logic       ss         [NU];
    logic       mosi       [NU];
    logic       miso       [NU];
    int         rise_ss_lo [NU];
    int         rise_all   [NU];
    int         last_gap   [NU];
    bit         bad_model  [NU];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int div_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 5);
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    for (genvar g = 0; g < NU; g++) begin : g_unit
        localparam int GD = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

        bitrev_spi_ctrl #(.DIV(GD)) dut (
            .clock      (clk),
            .resetn     (resetn[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_data   (req_data[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_data  (resp_data[g]),
            .busy       (busy[g]),
            .err        (err[g]),
            .spi_sck    (sck[g]),
            .spi_ss     (ss[g]),
            .spi_mosi   (mosi[g]),
            .spi_miso   (miso[g])
        );

        // Bitrev slave model
        int         s_cnt   = 0;
        bit         s_send  = 0;
        logic [7:0] s_rx    = 8'd0;
        logic [7:0] s_tx    = 8'd0;
        logic       s_miso  = 1'b0;
        int         hi_run  = 0;
        int         n_lo    = 0;
        int         n_all   = 0;
        int         gap     = 0;

        assign miso[g]       = s_miso;
        assign rise_ss_lo[g] = n_lo;
        assign rise_all[g]   = n_all;
        assign last_gap[g]   = gap;

        always @(posedge sck[g]) begin
            n_all++;
            if (ss[g]) begin
                s_cnt  = 0;
                s_send = 0;
                s_miso = 1'b0;
            end else begin
                n_lo++;
                if (!s_send) begin
                    s_rx = {s_rx[6:0], mosi[g]};
                    s_cnt++;
                    if (s_cnt == 8) begin
                        s_send = 1;
                        s_tx = (bad_model[g] && s_rx == 8'h81) ? 8'h00 : rev8(s_rx);
                    end
                end else begin
                    s_miso = s_tx[7];
                    s_tx   = {s_tx[6:0], 1'b0};
                end
            end
        end

        always @(negedge clk) begin
            if (ss[g]) begin
                hi_run++;
            end else begin
                if (hi_run > 0) gap = hi_run;
                hi_run = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        n_chk++;
        if (act < lim) begin
            $display("FAIL %s: got %0d expected at least %0d", name, act, lim);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one request on unit u and wait for resp_valid. Returns at the
    // negedge where resp_valid is first seen; lat counts clock edges after
    // the accepting edge.
    task automatic run_txn(input int u, input logic [7:0] d, output logic [7:0] r,
                           output int lat, output int pulses, output logic e);
        int guard = 0;
        int base;
        @(negedge clk);
        while (!req_ready[u] && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", int'(req_ready[u]), 1);
        req_valid[u] = 1'b1;
        req_data[u]  = d;
        base = rise_ss_lo[u];
        @(posedge clk);
        @(negedge clk);
        req_valid[u] = 1'b0;
        lat = 0;
        while (!resp_valid[u] && lat < 40 * 255) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("resp_valid_timeout", int'(resp_valid[u]), 1);
        r      = resp_data[u];
        e      = err[u];
        pulses = rise_ss_lo[u] - base;
    endtask

    task automatic release_resp(input int u);
        resp_ready[u] = 1'b1;
        @(negedge clk);
        resp_ready[u] = 1'b0;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] r;
        logic       e;
        int         lat;
        int         pulses;
        int         ok;
        int         base_all;
        logic [7:0] held;
        logic [7:0] r1;
        int         exp_err;

        vecs[0] = '{tx: 8'h01, rx: 8'h80};
        vecs[1] = '{tx: 8'hA5, rx: 8'hA5};
        vecs[2] = '{tx: 8'h3C, rx: 8'h3C};
        vecs[3] = '{tx: 8'hF0, rx: 8'h0F};
        vecs[4] = '{tx: 8'h6E, rx: 8'h76};
        vecs[5] = '{tx: 8'h12, rx: 8'h48};
        vecs[6] = '{tx: 8'h00, rx: 8'h00};
        vecs[7] = '{tx: 8'hFF, rx: 8'hFF};

        for (int u = 0; u < NU; u++) begin
            resetn[u]     = 1'b0;
            req_valid[u]  = 1'b0;
            req_data[u]   = 8'h00;
            resp_ready[u] = 1'b0;
            bad_model[u]  = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ss", int'(ss[0]), 1);
        check("rst_sck", int'(sck[0]), 0);
        check("rst_mosi", int'(mosi[0]), 0);
        check("rst_resp_valid", int'(resp_valid[0]), 0);
        check("rst_resp_data", int'(resp_data[0]), 0);
        check("rst_err", int'(err[0]), 0);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_req_ready", int'(req_ready[0]), 1);
        for (int u = 0; u < NU; u++) resetn[u] = 1'b1;

        // Table-driven transactions, DIV=2
        for (int i = 0; i < 8; i++) begin
            run_txn(0, vecs[i].tx, r, lat, pulses, e);
            check($sformatf("vec%0d_data", i), int'(r), int'(vecs[i].rx));
            check($sformatf("vec%0d_latency", i), lat, 68);
            check($sformatf("vec%0d_ss_pulses", i), pulses, 16);
            check($sformatf("vec%0d_err", i), int'(e), 0);
            check($sformatf("vec%0d_busy", i), int'(busy[0]), 1);
            release_resp(0);
            check($sformatf("vec%0d_idle", i), int'(resp_valid[0]), 0);
        end

        // Back-to-back with resp_ready held high
        resp_ready[0] = 1'b1;
        run_txn(0, 8'hA5, r1, lat, pulses, e);
        run_txn(0, 8'h3C, r, lat, pulses, e);
        check("b2b_first", int'(r1), 8'hA5);
        check("b2b_second", int'(r), 8'h3C);
        check_ge("b2b_ss_gap", last_gap[0], div_of(0) + 1);
        @(negedge clk);
        resp_ready[0] = 1'b0;

        // Response held while resp_ready low; requests ignored meanwhile
        run_txn(0, 8'h12, r, lat, pulses, e);
        held     = resp_data[0];
        base_all = rise_all[0];
        ok       = 1;
        req_valid[0] = 1'b1;
        req_data[0]  = 8'h77;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!resp_valid[0] || resp_data[0] !== held || req_ready[0] || sck[0]) ok = 0;
        end
        req_valid[0] = 1'b0;
        check("hold_stable", ok, 1);
        check("hold_data", int'(held), 8'h48);
        check("hold_no_sck", rise_all[0] - base_all, 0);
        release_resp(0);

        // Reset during TX bit 3
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_data[0]  = 8'h5A;
        base_all = rise_ss_lo[0];
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (8 * div_of(0)) @(negedge clk);
        check("abort_in_bit3", rise_ss_lo[0] - base_all, 3);
        check("abort_busy_before", int'(busy[0]), 1);
        resetn[0] = 1'b0;
        @(negedge clk);
        check("abort_ss", int'(ss[0]), 1);
        check("abort_sck", int'(sck[0]), 0);
        check("abort_busy", int'(busy[0]), 0);
        check("abort_resp_valid", int'(resp_valid[0]), 0);
        resetn[0] = 1'b1;
        run_txn(0, 8'hF0, r, lat, pulses, e);
        check("after_abort_data", int'(r), 8'h0F);
        check("after_abort_latency", lat, 68);
        release_resp(0);

        // Loop check with a faulty slave
`ifdef BITREV_CTRL_LOOPCHK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        bad_model[0] = 1;
        run_txn(0, 8'h81, r, lat, pulses, e);
        check("bad_model_data", int'(r), 8'h00);
        check("bad_model_err", int'(e), exp_err);
        release_resp(0);
        check("err_cleared_idle", int'(err[0]), 0);
        bad_model[0] = 0;
        run_txn(0, 8'h81, r, lat, pulses, e);
        check("good_model_data", int'(r), 8'h81);
        check("good_model_err", int'(e), 0);
        release_resp(0);

        // Other dividers
        run_txn(1, 8'h6E, r, lat, pulses, e);
        check("div1_data", int'(r), 8'h76);
        check("div1_latency", lat, 34);
        check("div1_ss_pulses", pulses, 16);
        release_resp(1);
        run_txn(2, 8'h6E, r, lat, pulses, e);
        check("div5_data", int'(r), 8'h76);
        check("div5_latency", lat, 170);
        check("div5_ss_pulses", pulses, 16);
        release_resp(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
